// File: rtl/lelo_meas_pkg.sv
// rtl/lelo_meas_pkg.sv - shared state type and channel-search helpers for temp_osc_scan
package lelo_meas_pkg;

   localparam int MAX_CH = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_COUNT,
      ST_STORE
   } meas_state_t;

   typedef struct packed {
      logic       wrap;
      logic [3:0] idx;
   } next_ch_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lowest set bit above cur (or from bit 0 when from_zero). When none exists,
   // wrap is set and idx names the lowest set bit of the whole mask instead.
   function automatic next_ch_t next_masked(input logic [MAX_CH-1:0] mask,
                                            input logic [3:0]        cur,
                                            input logic              from_zero);
      next_ch_t   r;
      logic [3:0] lo;
      logic [3:0] hi;
      logic       lo_found;
      logic       hi_found;
      lo       = '0;
      hi       = '0;
      lo_found = 1'b0;
      hi_found = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (mask[i] && !lo_found) begin
            lo       = 4'(i);
            lo_found = 1'b1;
         end
         if (mask[i] && !hi_found && (from_zero || (4'(i) > cur))) begin
            hi       = 4'(i);
            hi_found = 1'b1;
         end
      end
      r.wrap = !hi_found;
      r.idx  = hi_found ? hi : lo;
      return r;
   endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - one oscillator input: synchronizer, history flop, rising-edge pulse
module osc_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic lf_clk,
   input  logic rst_n,
   input  logic i_osc,
   input  logic i_load,
   input  logic i_en,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge lf_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync[0] <= i_osc;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         // History only moves while the channel is selected, so a stale level
         // from a previous sweep can never look like a fresh edge.
         if (i_load || i_en) begin
            r_hist <= w_sync;
         end
      end
   end

   assign o_edge = i_en && w_sync && !r_hist;

endmodule

// File: rtl/temp_osc_scan.sv
// rtl/temp_osc_scan.sv - sequences NCH temperature oscillators and counts edges per window
module temp_osc_scan
   import lelo_meas_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int CNT_W       = 10,
   parameter int WIN_W       = 16,
   parameter int SETTLE      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CH_W        = ch_width(NCH)
) (
   input  logic             lf_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic [NCH-1:0]   ch_mask,
   input  logic [WIN_W-1:0] win_cycles,
   input  logic [NCH-1:0]   osc_in,
   output logic [NCH-1:0]   ana_en,
   output logic             busy,
   output logic             done,
   output logic [CH_W-1:0]  ch_idx,
   output logic [CNT_W-1:0] cycles,
   output logic             sat,
   output logic             sweep_done
);

   localparam int               ST_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   meas_state_t      r_state, w_state_nxt;
   logic [NCH-1:0]   r_mask, w_mask_nxt;
   logic [WIN_W-1:0] r_win, w_win_nxt;
   logic [CH_W-1:0]  r_ch, w_ch_nxt;
   logic [ST_W-1:0]  r_settle, w_settle_nxt;
   logic [WIN_W-1:0] r_wcnt, w_wcnt_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [NCH-1:0]   r_ana_en, w_ana_en_nxt;
   logic             r_done, w_done_nxt;
   logic             r_sweep_done, w_sweep_done_nxt;
   logic [CH_W-1:0]  r_ch_idx, w_ch_idx_nxt;
   logic [CNT_W-1:0] r_cycles, w_cycles_nxt;
   logic             r_sat, w_sat_nxt;

   logic [MAX_CH-1:0] w_live16;
   logic [MAX_CH-1:0] w_reg16;
   logic [3:0]        w_cur4;
   next_ch_t          w_first;
   next_ch_t          w_next;
   logic [CH_W-1:0]   w_first_ch;
   logic [CH_W-1:0]   w_next_ch;
   logic [NCH-1:0]    w_edges;
   logic [NCH-1:0]    w_load;
   logic [NCH-1:0]    w_en;
   logic              w_edge;

   always_comb begin
      w_live16             = '0;
      w_live16[NCH-1:0]    = ch_mask;
      w_reg16              = '0;
      w_reg16[NCH-1:0]     = r_mask;
      w_cur4               = '0;
      w_cur4[CH_W-1:0]     = r_ch;
   end

   assign w_first    = next_masked(w_live16, 4'd0, 1'b1);
   assign w_next     = next_masked(w_reg16, w_cur4, 1'b0);
   assign w_first_ch = CH_W'(w_first.idx);
   assign w_next_ch  = CH_W'(w_next.idx);

   // ana_en is the one-hot of r_ch whenever busy, so it doubles as the channel select.
   assign w_load = (r_state == ST_SETTLE) ? r_ana_en : '0;
   assign w_en   = (r_state == ST_COUNT)  ? r_ana_en : '0;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      osc_edge_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .lf_clk (lf_clk),
         .rst_n  (rst_n),
         .i_osc  (osc_in[g]),
         .i_load (w_load[g]),
         .i_en   (w_en[g]),
         .o_edge (w_edges[g])
      );
   end

   assign w_edge = w_edges[r_ch];

   always_comb begin
      w_state_nxt      = r_state;
      w_mask_nxt       = r_mask;
      w_win_nxt        = r_win;
      w_ch_nxt         = r_ch;
      w_settle_nxt     = r_settle;
      w_wcnt_nxt       = r_wcnt;
      w_cnt_nxt        = r_cnt;
      w_ana_en_nxt     = r_ana_en;
      w_done_nxt       = 1'b0;
      w_sweep_done_nxt = 1'b0;
      w_ch_idx_nxt     = r_ch_idx;
      w_cycles_nxt     = r_cycles;
      w_sat_nxt        = r_sat;
      unique case (r_state)
         ST_IDLE: begin
            if (start && !w_first.wrap) begin
               w_state_nxt  = ST_SETTLE;
               w_mask_nxt   = ch_mask;
               w_win_nxt    = (win_cycles == '0) ? WIN_W'(1) : win_cycles;
               w_ch_nxt     = w_first_ch;
               w_ch_idx_nxt = w_first_ch;
               w_ana_en_nxt = NCH'(1) << w_first_ch;
               w_settle_nxt = '0;
               w_cnt_nxt    = '0;
            end
         end
         ST_SETTLE: begin
            w_cnt_nxt = '0;
            if (r_settle == ST_W'(SETTLE - 1)) begin
               w_state_nxt = ST_COUNT;
               w_wcnt_nxt  = '0;
            end else begin
               w_settle_nxt = r_settle + ST_W'(1);
            end
         end
         ST_COUNT: begin
            if (w_edge && (r_cnt != CNT_MAX)) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            if (r_wcnt == r_win - WIN_W'(1)) begin
               w_state_nxt = ST_STORE;
            end else begin
               w_wcnt_nxt = r_wcnt + WIN_W'(1);
            end
         end
         ST_STORE: begin
            w_done_nxt   = 1'b1;
            w_cycles_nxt = r_cnt;
            w_sat_nxt    = (r_cnt == CNT_MAX);
            w_ch_idx_nxt = r_ch;
            w_settle_nxt = '0;
            if (!w_next.wrap) begin
               w_state_nxt  = ST_SETTLE;
               w_ch_nxt     = w_next_ch;
               w_ana_en_nxt = NCH'(1) << w_next_ch;
            end else begin
               w_sweep_done_nxt = 1'b1;
               // A continuous restart is a new sweep, so mask and window are re-captured.
               if (cont && start && !w_first.wrap) begin
                  w_state_nxt  = ST_SETTLE;
                  w_mask_nxt   = ch_mask;
                  w_win_nxt    = (win_cycles == '0) ? WIN_W'(1) : win_cycles;
                  w_ch_nxt     = w_first_ch;
                  w_ana_en_nxt = NCH'(1) << w_first_ch;
               end else begin
                  w_state_nxt  = ST_IDLE;
                  w_ana_en_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_ana_en_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge lf_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_mask       <= '0;
         r_win        <= '0;
         r_ch         <= '0;
         r_settle     <= '0;
         r_wcnt       <= '0;
         r_cnt        <= '0;
         r_ana_en     <= '0;
         r_done       <= 1'b0;
         r_sweep_done <= 1'b0;
         r_ch_idx     <= '0;
         r_cycles     <= '0;
         r_sat        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_mask       <= w_mask_nxt;
         r_win        <= w_win_nxt;
         r_ch         <= w_ch_nxt;
         r_settle     <= w_settle_nxt;
         r_wcnt       <= w_wcnt_nxt;
         r_cnt        <= w_cnt_nxt;
         r_ana_en     <= w_ana_en_nxt;
         r_done       <= w_done_nxt;
         r_sweep_done <= w_sweep_done_nxt;
         r_ch_idx     <= w_ch_idx_nxt;
         r_cycles     <= w_cycles_nxt;
         r_sat        <= w_sat_nxt;
      end
   end

   assign ana_en     = r_ana_en;
   assign busy       = (r_state != ST_IDLE);
   assign done       = r_done;
   assign sweep_done = r_sweep_done;
   assign ch_idx     = r_ch_idx;
   assign cycles     = r_cycles;
   assign sat        = r_sat;

   a_settle_min: assert property (@(posedge lf_clk) SETTLE >= SYNC_STAGES + 1);
   a_ana_onehot: assert property (@(posedge lf_clk) disable iff (!rst_n) $onehot0(r_ana_en));
   a_done_store: assert property (@(posedge lf_clk) disable iff (!rst_n)
                                  r_done |-> ($past(r_state) == ST_STORE && r_state != ST_STORE));

endmodule

// File: tb/tb_temp_osc_scan.sv
// tb/tb_temp_osc_scan.sv - self-checking bench for temp_osc_scan
module tb_temp_osc_scan;

   localparam int SETTLE = 8;
   localparam int SYNC   = 2;
   localparam int CMAX   = 1023;

   logic        lf_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic [3:0]  ch_mask = '0;
   logic [15:0] win_cycles = '0;
   logic [3:0]  osc_in;
   logic [3:0]  ana_en;
   logic        busy, done, sat, sweep_done;
   logic [1:0]  ch_idx;
   logic [9:0]  cycles;

   temp_osc_scan #(.NCH(4), .CNT_W(10), .WIN_W(16), .SETTLE(SETTLE), .SYNC_STAGES(SYNC)) dut (
      .lf_clk(lf_clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_mask(ch_mask),
      .win_cycles(win_cycles), .osc_in(osc_in), .ana_en(ana_en), .busy(busy), .done(done),
      .ch_idx(ch_idx), .cycles(cycles), .sat(sat), .sweep_done(sweep_done));

   always #5 lf_clk = ~lf_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Oscillators: free-running square waves with integer periods, changing on negedge.
   int         per [4];
   int         ph  [4];
   logic [3:0] osc_auto = '0;
   logic [3:0] osc_man = '0;
   logic       man_mode = 1'b0;
   assign osc_in = man_mode ? osc_man : osc_auto;

   always @(negedge lf_clk) begin
      for (int c = 0; c < 4; c++) begin
         if (per[c] == 0) osc_auto[c] = 1'b0;
         else begin
            ph[c] = (ph[c] + 1) % per[c];
            osc_auto[c] = (ph[c] < per[c] / 2);
         end
      end
   end

   int         cyc = 0;
   logic [3:0] samp [0:65535];
   always @(posedge lf_clk) begin
      cyc <= cyc + 1;
      samp[cyc + 1] <= osc_in;
   end

   typedef struct { int d; int ch; int cnt; int sat; int swd; int ana; } res_t;
   res_t res_q[$];
   always @(negedge lf_clk)
      if (rst_n && done)
         res_q.push_back('{cyc, int'(ch_idx), int'(cycles), int'(sat), int'(sweep_done), int'(ana_en)});

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // A rise seen by the first synchronizer flop at edge t reaches the counter at edge t+SYNC;
   // it counts when that edge lies in the window, i.e. in the win edges before done.
   function automatic int model_cnt(input int d, input int w, input int ch);
      int n = 0;
      for (int e = d - w; e < d; e++)
         if (samp[e - SYNC][ch] === 1'b1 && samp[e - SYNC - 1][ch] === 1'b0) n++;
      return n;
   endfunction

   task automatic check_results(input int k, input int w, input int chs[$], input int nres, input string tag);
      int p;
      int len;
      p = SETTLE + w + 1;
      len = chs.size();
      chk($sformatf("%s n_results", tag), res_q.size(), nres);
      for (int i = 0; i < nres && i < res_q.size(); i++) begin
         int d   = k + (i + 1) * p;
         int ch  = chs[i % len];
         int raw = model_cnt(d, w, ch);
         int nxt = (i == nres - 1) ? 0 : (1 << chs[(i + 1) % len]);
         chk($sformatf("%s r%0d done_edge", tag, i), res_q[i].d, d);
         chk($sformatf("%s r%0d ch_idx", tag, i), res_q[i].ch, ch);
         chk($sformatf("%s r%0d cycles", tag, i), res_q[i].cnt, (raw > CMAX) ? CMAX : raw);
         chk($sformatf("%s r%0d sat", tag, i), res_q[i].sat, (raw >= CMAX) ? 1 : 0);
         chk($sformatf("%s r%0d sweep_done", tag, i), res_q[i].swd, (i % len == len - 1) ? 1 : 0);
         chk($sformatf("%s r%0d ana_en", tag, i), res_q[i].ana, nxt);
      end
   endtask

   task automatic run_sweep(input logic [3:0] m, input int w, input int exp_first,
                            input int n_exp, input string tag);
      int k, weff, lim;
      int chs[$];
      weff = (w == 0) ? 1 : w;
      for (int c = 0; c < 4; c++) if (m[c]) chs.push_back(c);
      res_q.delete();
      start = 1'b1; ch_mask = m; win_cycles = 16'(w); k = cyc + 1;
      @(negedge lf_clk);
      chk({tag, " busy_after_start"}, int'(busy), 1);
      chk({tag, " ana_en_first"}, int'(ana_en), 1 << chs[0]);
      start = 1'b0; ch_mask = 4'($urandom); win_cycles = 16'($urandom);
      lim = k + (chs.size() + 1) * (SETTLE + weff + 1) + 10;
      while (res_q.size() < n_exp && cyc < lim) @(negedge lf_clk);
      repeat (SETTLE + weff + 4) @(negedge lf_clk);
      chk({tag, " busy_at_end"}, int'(busy), 0);
      if (exp_first >= 0 && res_q.size() > 0)
         chk({tag, " first_cycles_const"}, res_q[0].cnt, exp_first);
      check_results(k, weff, chs, n_exp, tag);
   endtask

   typedef struct { logic [3:0] mask; int win; int p0, p1, p2, p3; int exp_first; int n_exp; } vec_t;
   vec_t tbl [8];

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int k, lim;
      int cs[$];
      tbl[0] = '{4'b0001, 100, 10, 0, 0, 0, 10, 1};
      tbl[1] = '{4'b1010, 100, 0, 10, 0, 5, 10, 2};
      tbl[2] = '{4'b0100, 0, 0, 0, 4, 0, -1, 1};
      tbl[3] = '{4'b0010, 4200, 0, 4, 0, 0, 1023, 1};
      tbl[4] = '{4'b1111, 37, 7, 9, 11, 13, -1, 4};
      for (int i = 5; i < 8; i++) begin
         tbl[i].mask = 4'($urandom_range(1, 15));
         tbl[i].win  = $urandom_range(1, 60);
         tbl[i].p0 = $urandom_range(4, 24); tbl[i].p1 = $urandom_range(4, 24);
         tbl[i].p2 = $urandom_range(4, 24); tbl[i].p3 = $urandom_range(4, 24);
         tbl[i].exp_first = -1;
         tbl[i].n_exp = $countones(tbl[i].mask);
      end

      repeat (3) @(negedge lf_clk);
      chk("reset ana_en", int'(ana_en), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset sweep_done", int'(sweep_done), 0);
      chk("reset ch_idx", int'(ch_idx), 0);
      chk("reset cycles", int'(cycles), 0);
      chk("reset sat", int'(sat), 0);
      rst_n = 1'b1;
      @(negedge lf_clk);

      start = 1'b1; ch_mask = 4'b0000; win_cycles = 16'd10;
      repeat (6) begin
         @(negedge lf_clk);
         chk("mask0 busy", int'(busy), 0);
      end
      start = 1'b0;
      chk("mask0 no_done", res_q.size(), 0);

      foreach (tbl[i]) begin
         per[0] = tbl[i].p0; per[1] = tbl[i].p1; per[2] = tbl[i].p2; per[3] = tbl[i].p3;
         for (int c = 0; c < 4; c++) ph[c] = $urandom_range(0, 30);
         repeat (4) @(negedge lf_clk);
         run_sweep(tbl[i].mask, tbl[i].win, tbl[i].exp_first, tbl[i].n_exp, $sformatf("vec%0d", i));
      end

      // Continuous mode with start held, then start dropped during a ch0 measurement.
      per[0] = 6; per[1] = 0; per[2] = 9; per[3] = 0;
      repeat (4) @(negedge lf_clk);
      res_q.delete();
      cont = 1'b1; start = 1'b1; ch_mask = 4'b0101; win_cycles = 16'd20; k = cyc + 1;
      lim = k + 8 * (SETTLE + 21);
      while (res_q.size() < 4 && cyc < lim) @(negedge lf_clk);
      repeat (5) @(negedge lf_clk);
      start = 1'b0;
      while (res_q.size() < 6 && cyc < lim) @(negedge lf_clk);
      repeat (40) @(negedge lf_clk);
      cont = 1'b0;
      chk("cont busy_at_end", int'(busy), 0);
      cs.push_back(0); cs.push_back(2);
      check_results(k, 20, cs, 6, "cont");

      // One rise landing on the final window edge is counted; one edge later it is lost.
      man_mode = 1'b1; osc_man = '0;
      repeat (5) @(negedge lf_clk);
      for (int t = 0; t < 2; t++) begin
         res_q.delete();
         start = 1'b1; ch_mask = 4'b0010; win_cycles = 16'd5; k = cyc + 1;
         @(negedge lf_clk);
         start = 1'b0;
         while (cyc < k + 10 + t) @(negedge lf_clk);
         osc_man[1] = 1'b1;
         while (res_q.size() < 1 && cyc < k + 40) @(negedge lf_clk);
         chk($sformatf("lastedge%0d n_results", t), res_q.size(), 1);
         if (res_q.size() > 0) begin
            chk($sformatf("lastedge%0d done_edge", t), res_q[0].d, k + SETTLE + 5 + 1);
            chk($sformatf("lastedge%0d cycles", t), res_q[0].cnt, (t == 0) ? 1 : 0);
         end
         osc_man = '0;
         repeat (10) @(negedge lf_clk);
      end
      man_mode = 1'b0;

      // Asynchronous reset in the middle of a counting window.
      per[0] = 4; per[1] = 5; per[2] = 6; per[3] = 7;
      res_q.delete();
      start = 1'b1; ch_mask = 4'b1111; win_cycles = 16'd50; k = cyc + 1;
      @(negedge lf_clk);
      start = 1'b0;
      while (cyc < k + SETTLE + 10) @(negedge lf_clk);
      chk("pre_reset ana_en", int'(ana_en), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset ana_en", int'(ana_en), 0);
      chk("async_reset busy", int'(busy), 0);
      chk("async_reset others", int'({done, sweep_done, ch_idx, cycles, sat}), 0);
      @(negedge lf_clk);
      rst_n = 1'b1;
      @(negedge lf_clk);
      chk("post_reset no_done", res_q.size(), 0);
      repeat (4) @(negedge lf_clk);
      run_sweep(4'b1001, 30, -1, 2, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
